// File: rtl/vdf_3_a_seq_gen.sv
// vdf_3_a_seq_gen: stimulus transmitter and response checker for the vdf_3_a
// staggered sequence detector. Each accepted {a,b,c,d,e} token is skewed onto the
// detector drives (D/E, then C, B, A on successive cycles). The detector OUT is
// sampled while A is driven and compared against the expected result.
module vdf_3_a_seq_gen #(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned FLUSH_CYC = 3
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             CMD_VALID,
   output logic             CMD_READY,
   input  logic [4:0]       CMD_DATA,
   input  logic             CLR,
   output logic             A,
   output logic             B,
   output logic             C,
   output logic             D,
   output logic             E,
   input  logic             OUT_IN,
   output logic             RESP_VALID,
   output logic             RESP_EXP,
   output logic             RESP_ACT,
   output logic [CNT_W-1:0] PASS_CNT,
   output logic [CNT_W-1:0] FAIL_CNT,
   output logic             ERR,
   output logic             BUSY
);

   localparam int unsigned FLUSH_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

   typedef enum logic {
      ST_FLUSH = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
   logic               ready_q, ready_d;

   // Pipeline stage k holds the token whose stage-k drive is on the pins this cycle.
   logic               s1_v_q, s1_v_d;
   logic [2:0]         s1_abc_q, s1_abc_d;
   logic               s1_exp_q, s1_exp_d;
   logic               s2_v_q, s2_v_d;
   logic [1:0]         s2_ab_q, s2_ab_d;
   logic               s2_exp_q, s2_exp_d;
   logic               s3_v_q, s3_v_d;
   logic               s3_a_q, s3_a_d;
   logic               s3_exp_q, s3_exp_d;
   logic               s4_v_q, s4_v_d;
   logic               s4_exp_q, s4_exp_d;

   logic               a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d, e_q, e_d;
   logic               resp_valid_q, resp_valid_d;
   logic               resp_exp_q, resp_exp_d;
   logic               resp_act_q, resp_act_d;
   logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;

   logic               accept;
   logic               match;

   // Next-state logic: flush FSM, skew pipeline, response and counters.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      ready_d     = ready_q;

      unique case (state_q)
         ST_FLUSH: begin
            ready_d = 1'b0;
            if (flush_cnt_q == FLUSH_W'(FLUSH_CYC - 1)) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
            end else begin
               flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
            end
         end
         ST_RUN: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = ST_FLUSH;
            ready_d = 1'b0;
         end
      endcase

      accept = CMD_VALID & ready_q;

      // Stage 1: D/E go out straight from the accepted token.
      s1_v_d   = accept;
      s1_abc_d = CMD_DATA[4:2];
      s1_exp_d = CMD_DATA[4] & CMD_DATA[3] & CMD_DATA[2] & ~(CMD_DATA[1] & CMD_DATA[0]);
      d_d      = accept & CMD_DATA[1];
      e_d      = accept & CMD_DATA[0];

      // Stage 2: C.
      s2_v_d   = s1_v_q;
      s2_ab_d  = s1_abc_q[2:1];
      s2_exp_d = s1_exp_q;
      c_d      = s1_v_q & s1_abc_q[0];

      // Stage 3: B.
      s3_v_d   = s2_v_q;
      s3_a_d   = s2_ab_q[1];
      s3_exp_d = s2_exp_q;
      b_d      = s2_v_q & s2_ab_q[0];

      // Stage 4: A; OUT_IN is sampled at the end of this stage.
      s4_v_d   = s3_v_q;
      s4_exp_d = s3_exp_q;
      a_d      = s3_v_q & s3_a_q;

      // Response stage.
      match        = (s4_exp_q == OUT_IN);
      resp_valid_d = s4_v_q;
      resp_exp_d   = s4_v_q & s4_exp_q;
      resp_act_d   = s4_v_q & OUT_IN;

      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      err_d      = err_q;
      // Clear takes precedence over a coinciding response, which is then not counted.
      if (CLR) begin
         pass_cnt_d = '0;
         fail_cnt_d = '0;
         err_d      = 1'b0;
      end else if (s4_v_q) begin
         if (match) begin
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
         end else begin
            if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
            err_d = 1'b1;
         end
      end

      busy_d = s1_v_d | s2_v_d | s3_v_d | s4_v_d | resp_valid_d;
   end

   // State and output registers; reset drops in-flight tokens and re-enters flush.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= ST_FLUSH;
         flush_cnt_q  <= '0;
         ready_q      <= 1'b0;
         s1_v_q       <= 1'b0;
         s1_abc_q     <= '0;
         s1_exp_q     <= 1'b0;
         s2_v_q       <= 1'b0;
         s2_ab_q      <= '0;
         s2_exp_q     <= 1'b0;
         s3_v_q       <= 1'b0;
         s3_a_q       <= 1'b0;
         s3_exp_q     <= 1'b0;
         s4_v_q       <= 1'b0;
         s4_exp_q     <= 1'b0;
         a_q          <= 1'b0;
         b_q          <= 1'b0;
         c_q          <= 1'b0;
         d_q          <= 1'b0;
         e_q          <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_exp_q   <= 1'b0;
         resp_act_q   <= 1'b0;
         pass_cnt_q   <= '0;
         fail_cnt_q   <= '0;
         err_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         ready_q      <= ready_d;
         s1_v_q       <= s1_v_d;
         s1_abc_q     <= s1_abc_d;
         s1_exp_q     <= s1_exp_d;
         s2_v_q       <= s2_v_d;
         s2_ab_q      <= s2_ab_d;
         s2_exp_q     <= s2_exp_d;
         s3_v_q       <= s3_v_d;
         s3_a_q       <= s3_a_d;
         s3_exp_q     <= s3_exp_d;
         s4_v_q       <= s4_v_d;
         s4_exp_q     <= s4_exp_d;
         a_q          <= a_d;
         b_q          <= b_d;
         c_q          <= c_d;
         d_q          <= d_d;
         e_q          <= e_d;
         resp_valid_q <= resp_valid_d;
         resp_exp_q   <= resp_exp_d;
         resp_act_q   <= resp_act_d;
         pass_cnt_q   <= pass_cnt_d;
         fail_cnt_q   <= fail_cnt_d;
         err_q        <= err_d;
         busy_q       <= busy_d;
      end
   end

   assign CMD_READY  = ready_q;
   assign A          = a_q;
   assign B          = b_q;
   assign C          = c_q;
   assign D          = d_q;
   assign E          = e_q;
   assign RESP_VALID = resp_valid_q;
   assign RESP_EXP   = resp_exp_q;
   assign RESP_ACT   = resp_act_q;
   assign PASS_CNT   = pass_cnt_q;
   assign FAIL_CNT   = fail_cnt_q;
   assign ERR        = err_q;
   assign BUSY       = busy_q;

endmodule

// File: tb/tb_vdf_3_a_seq_gen.sv
// Bench for vdf_3_a_seq_gen: a behavioural vdf_3_a detector closes the loop,
// a scoreboard queue holds expected responses, and a second instance with a
// 2-bit counter width shares the stimulus to exercise saturation.
module tb_vdf_3_a_seq_gen;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic       CMD_VALID;
   logic       CMD_READY;
   logic [4:0] CMD_DATA;
   logic       CLR;
   logic       A, B, C, D, E;
   logic       OUT_IN;
   logic       RESP_VALID, RESP_EXP, RESP_ACT;
   logic [15:0] PASS_CNT, FAIL_CNT;
   logic       ERR, BUSY;

   logic       u2_ready, u2_a, u2_b, u2_c, u2_d, u2_e;
   logic       u2_resp_valid, u2_resp_exp, u2_resp_act;
   logic [1:0] u2_pass, u2_fail;
   logic       u2_err, u2_busy;

   logic       force_en = 1'b0;
   logic       force_val = 1'b0;

   int unsigned cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic        exp;
      logic        act;
      int unsigned due;
   } sb_t;
   sb_t sb[$];

   vdf_3_a_seq_gen #(.CNT_W(16), .FLUSH_CYC(3)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_DATA(CMD_DATA), .CLR(CLR), .A(A), .B(B), .C(C), .D(D), .E(E),
      .OUT_IN(OUT_IN), .RESP_VALID(RESP_VALID), .RESP_EXP(RESP_EXP), .RESP_ACT(RESP_ACT),
      .PASS_CNT(PASS_CNT), .FAIL_CNT(FAIL_CNT), .ERR(ERR), .BUSY(BUSY)
   );

   vdf_3_a_seq_gen #(.CNT_W(2), .FLUSH_CYC(3)) u_dut2 (
      .CLK(CLK), .RST_N(RST_N), .CMD_VALID(CMD_VALID), .CMD_READY(u2_ready),
      .CMD_DATA(CMD_DATA), .CLR(CLR), .A(u2_a), .B(u2_b), .C(u2_c), .D(u2_d), .E(u2_e),
      .OUT_IN(OUT_IN), .RESP_VALID(u2_resp_valid), .RESP_EXP(u2_resp_exp), .RESP_ACT(u2_resp_act),
      .PASS_CNT(u2_pass), .FAIL_CNT(u2_fail), .ERR(u2_err), .BUSY(u2_busy)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Behavioural vdf_3_a: reset-less delay lines aligning D&E, C, B with A.
   logic det_b1, det_c1, det_c2, det_de1, det_de2, det_de3, det_out;
   always @(posedge CLK) begin
      det_b1  <= B;
      det_c1  <= C;
      det_c2  <= det_c1;
      det_de1 <= D & E;
      det_de2 <= det_de1;
      det_de3 <= det_de2;
   end
   assign det_out = A & det_b1 & det_c2 & ~det_de3;
   assign OUT_IN  = force_en ? force_val : det_out;

   // Response monitor: every RESP_VALID pulse must match the head of the scoreboard.
   always @(negedge CLK) begin
      if (RST_N === 1'b1 && RESP_VALID === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_resp got=1 exp=0 cyc=%0d", cyc);
         end else begin
            sb_t e;
            e = sb.pop_front();
            if (cyc !== e.due) begin
               bad++;
               $display("FAIL resp_cycle got=%0d exp=%0d", cyc, e.due);
            end
            total++;
            if (RESP_EXP !== e.exp) begin
               bad++;
               $display("FAIL resp_exp got=%0b exp=%0b cyc=%0d", RESP_EXP, e.exp, cyc);
            end
            total++;
            if (RESP_ACT !== e.act) begin
               bad++;
               $display("FAIL resp_act got=%0b exp=%0b cyc=%0d", RESP_ACT, e.act, cyc);
            end
            total++;
            if ({u2_resp_valid, u2_resp_exp, u2_resp_act} !== {1'b1, e.exp, e.act}) begin
               bad++;
               $display("FAIL u2_resp got=%0b%0b%0b exp=1%0b%0b", u2_resp_valid, u2_resp_exp,
                        u2_resp_act, e.exp, e.act);
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clr_pulse();
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
   endtask

   // Drive one token for one cycle and record its expected response.
   task automatic issue(input logic [4:0] tok);
      logic e;
      e = tok[4] & tok[3] & tok[2] & ~(tok[1] & tok[0]);
      total++;
      if (CMD_READY !== 1'b1) begin
         bad++;
         $display("FAIL issue_ready got=%0b exp=1", CMD_READY);
      end
      CMD_VALID = 1'b1;
      CMD_DATA  = tok;
      sb.push_back('{exp: e, act: (force_en ? force_val : e), due: cyc + 5});
      tick();
   endtask

   // Checks FLUSH_CYC cycles of CMD_READY=0 with quiet drives, then CMD_READY=1.
   task automatic check_flush();
      for (int unsigned i = 0; i < 3; i++) begin
         total++;
         if ({CMD_READY, A, B, C, D, E} !== 6'b0) begin
            bad++;
            $display("FAIL flush_%0d got=%b exp=000000", i, {CMD_READY, A, B, C, D, E});
         end
         tick();
      end
      total++;
      if ({CMD_READY, u2_ready, A, B, C, D, E} !== 7'b1100000) begin
         bad++;
         $display("FAIL flush_done got=%b exp=1100000", {CMD_READY, u2_ready, A, B, C, D, E});
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0; CMD_VALID = 1'b1; CMD_DATA = 5'b11111; CLR = 1'b0;
      repeat (2) tick();
      total++;
      if ({CMD_READY, A, B, C, D, E, RESP_VALID, BUSY, ERR, PASS_CNT, FAIL_CNT} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%h exp=0",
                  {CMD_READY, A, B, C, D, E, RESP_VALID, BUSY, ERR, PASS_CNT, FAIL_CNT});
      end
      RST_N = 1'b1;
      check_flush();
      CMD_VALID = 1'b0;
      tick();
      // CMD_VALID held through flush must not have been accepted.
      total++;
      if ({D, E, BUSY} !== 3'b000) begin
         bad++;
         $display("FAIL flush_no_accept got=%b exp=000", {D, E, BUSY});
      end
   endtask

   task automatic test_single();
      logic [4:0] drv [1:4];
      drv[1] = 5'b00000; drv[2] = 5'b00100; drv[3] = 5'b01000; drv[4] = 5'b10000;
      clr_pulse();
      issue(5'b11100);
      CMD_VALID = 1'b0;
      for (int unsigned r = 1; r <= 4; r++) begin
         total++;
         if ({A, B, C, D, E, BUSY} !== {drv[r], 1'b1}) begin
            bad++;
            $display("FAIL single_drv_c%0d got=%b exp=%b", r, {A, B, C, D, E, BUSY}, {drv[r], 1'b1});
         end
         tick();
      end
      total++;
      if ({RESP_VALID, BUSY} !== 2'b11 || PASS_CNT !== 16'd1 || FAIL_CNT !== 16'd0) begin
         bad++;
         $display("FAIL single_resp got=v%0b b%0b p%0d f%0d exp=v1 b1 p1 f0",
                  RESP_VALID, BUSY, PASS_CNT, FAIL_CNT);
      end
      tick();
      total++;
      if ({RESP_VALID, BUSY} !== 2'b00) begin
         bad++;
         $display("FAIL single_idle got=%b exp=00", {RESP_VALID, BUSY});
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] toks [4];
      logic [4:0] drv [1:9];
      toks[0] = 5'b11100; toks[1] = 5'b11111; toks[2] = 5'b01100; toks[3] = 5'b11100;
      drv[1] = 5'b00000; drv[2] = 5'b00111; drv[3] = 5'b01100; drv[4] = 5'b11100;
      drv[5] = 5'b11100; drv[6] = 5'b01000; drv[7] = 5'b10000; drv[8] = 5'b00000;
      drv[9] = 5'b00000;
      clr_pulse();
      for (int unsigned i = 0; i < 4; i++) begin
         issue(toks[i]);
         total++;
         if ({A, B, C, D, E} !== drv[i+1]) begin
            bad++;
            $display("FAIL b2b_drv_c%0d got=%b exp=%b", i + 1, {A, B, C, D, E}, drv[i+1]);
         end
      end
      CMD_VALID = 1'b0;
      for (int unsigned r = 5; r <= 9; r++) begin
         tick();
         total++;
         if ({A, B, C, D, E} !== drv[r]) begin
            bad++;
            $display("FAIL b2b_drv_c%0d got=%b exp=%b", r, {A, B, C, D, E}, drv[r]);
         end
         if (r == 8) begin
            total++;
            if (PASS_CNT !== 16'd4 || FAIL_CNT !== 16'd0 || BUSY !== 1'b1) begin
               bad++;
               $display("FAIL b2b_counts got=p%0d f%0d b%0b exp=p4 f0 b1", PASS_CNT, FAIL_CNT, BUSY);
            end
         end
         if (r == 9) begin
            total++;
            if (BUSY !== 1'b0) begin
               bad++;
               $display("FAIL b2b_busy_end got=%0b exp=0", BUSY);
            end
         end
      end
   endtask

   task automatic test_mismatch();
      clr_pulse();
      force_en = 1'b1; force_val = 1'b1;
      repeat (3) tick();
      force_val = 1'b0;
      issue(5'b11100);
      CMD_VALID = 1'b0;
      repeat (4) tick();
      total++;
      if (FAIL_CNT !== 16'd1 || PASS_CNT !== 16'd0 || ERR !== 1'b1) begin
         bad++;
         $display("FAIL mism_resp got=p%0d f%0d e%0b exp=p0 f1 e1", PASS_CNT, FAIL_CNT, ERR);
      end
      repeat (3) tick();
      total++;
      if (ERR !== 1'b1) begin
         bad++;
         $display("FAIL mism_sticky got=%0b exp=1", ERR);
      end
      force_en = 1'b0;
      clr_pulse();
      total++;
      if (ERR !== 1'b0 || PASS_CNT !== 16'd0 || FAIL_CNT !== 16'd0) begin
         bad++;
         $display("FAIL mism_clr got=p%0d f%0d e%0b exp=p0 f0 e0", PASS_CNT, FAIL_CNT, ERR);
      end
   endtask

   task automatic test_saturate();
      logic [1:0] sat [5];
      sat[0] = 2'd1; sat[1] = 2'd2; sat[2] = 2'd3; sat[3] = 2'd3; sat[4] = 2'd3;
      clr_pulse();
      for (int unsigned i = 0; i < 5; i++) issue(5'b11100);
      CMD_VALID = 1'b0;
      for (int unsigned j = 0; j < 5; j++) begin
         total++;
         if (u2_pass !== sat[j] || PASS_CNT !== 16'(j + 1)) begin
            bad++;
            $display("FAIL sat_step%0d got=u2:%0d u1:%0d exp=u2:%0d u1:%0d",
                     j, u2_pass, PASS_CNT, sat[j], j + 1);
         end
         tick();
      end
      // Mismatching response coinciding with CLR: clear wins, nothing counted.
      force_en = 1'b1; force_val = 1'b0;
      issue(5'b11100);
      CMD_VALID = 1'b0;
      repeat (3) tick();
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      total++;
      if ({RESP_VALID, ERR, u2_err} !== 3'b100 || PASS_CNT !== 16'd0 || FAIL_CNT !== 16'd0
          || u2_pass !== 2'd0 || u2_fail !== 2'd0) begin
         bad++;
         $display("FAIL clr_with_resp got=v%0b e%0b p%0d f%0d u2p%0d u2f%0d exp=v1 e0 all 0",
                  RESP_VALID, ERR, PASS_CNT, FAIL_CNT, u2_pass, u2_fail);
      end
      force_en = 1'b0;
      tick();
   endtask

   task automatic test_reset_midburst();
      issue(5'b11100);
      issue(5'b11111);
      CMD_VALID = 1'b1;
      CMD_DATA  = 5'b01100;
      #2;
      RST_N = 1'b0;
      sb.delete();
      #1;
      total++;
      if ({CMD_READY, A, B, C, D, E, RESP_VALID, BUSY, ERR} !== 9'b0 || PASS_CNT !== 16'd0
          || {u2_ready, u2_busy, u2_pass} !== 4'b0) begin
         bad++;
         $display("FAIL midrst_outputs got=%b p%0d exp=0",
                  {CMD_READY, A, B, C, D, E, RESP_VALID, BUSY, ERR}, PASS_CNT);
      end
      CMD_VALID = 1'b0;
      repeat (2) tick();
      RST_N = 1'b1;
      check_flush();
      issue(5'b11100);
      CMD_VALID = 1'b0;
      repeat (4) tick();
      total++;
      if (PASS_CNT !== 16'd1 || FAIL_CNT !== 16'd0 || RESP_VALID !== 1'b1) begin
         bad++;
         $display("FAIL midrst_new got=p%0d f%0d v%0b exp=p1 f0 v1", PASS_CNT, FAIL_CNT, RESP_VALID);
      end
      repeat (2) tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_mismatch();
      test_saturate();
      test_reset_midburst();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL missing_resp got=%0d exp=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=%0d exp=finished", cyc);
      $fatal(1, "timeout");
   end

endmodule
